// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial add/subtract unit.
package serial_adder_pkg;

  // Sequencer states: waiting, shifting bits through the adder, result ready.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Positions of the ARM-style condition flags inside the 4-bit flag word.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Assemble the flag word from its individual condition bits.
  function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                            input logic c, input logic v);
    logic [3:0] f;
    f         = '0;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/serial_adder_unit_full_adder.sv
// One-bit gate-level full adder cell. The delay parameter documents the
// per-gate propagation delay of the library cell (critical path is three
// gates: xor -> and -> or); the netlist itself carries no timing.
module full_adder #(
  parameter int delay = 50
) (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic ab_x;
  logic ab_a;
  logic cx_a;

  // Reject nonsensical delay settings at elaboration.
  if (delay < 0) begin : g_bad_delay
    $error("full_adder: delay must be non-negative");
  end

  // Propagate term and sum.
  assign ab_x = a ^ b;
  assign sum  = ab_x ^ cin;

  // Generate and carry-through terms combine into the carry out.
  assign ab_a = a & b;
  assign cx_a = ab_x & cin;
  assign cout = ab_a | cx_a;

endmodule

// File: rtl/serial_adder_unit.sv
// Bit-serial A+B / A-B unit. Operands are shifted LSB first through a single
// full adder cell with a registered carry; after WIDTH bits the result and
// its NZCV flags are captured into output registers and done pulses once.
module serial_adder_unit
  import serial_adder_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int GATE_DELAY = 50
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic [3:0]       flags_o
);

  localparam int                 CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);

  // A one-bit operand leaves no room for a separate sign bit.
  if (WIDTH < 2) begin : g_bad_width
    $error("serial_adder_unit: WIDTH must be at least 2");
  end

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_next;
  logic [WIDTH-1:0] result_q;
  logic [3:0]       flags_q;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             fa_sum;
  logic             fa_cout;
  logic             accept;
  logic             last_bit;
  logic             c_msb;
  logic             zero_next;

  // A new request is only taken when no operation is in flight.
  assign accept   = start_i && ((state == IDLE) || (state == DONE));
  assign last_bit = (state == RUN) && (cnt == CNT_LAST);

  // The single arithmetic element of the data path.
  full_adder #(
    .delay (GATE_DELAY)
  ) u_fa (
    .a    (sa[0]),
    .b    (sb[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Result as it will look after this cycle's sum bit enters from the top.
  assign res_next  = {fa_sum, res_sh[WIDTH-1:1]};

  // Carry into the sign bit; compared with the carry out it gives overflow.
  assign c_msb     = carry;

  // Zero detect on the completed result.
  assign zero_next = ~|res_next;

  // Next-state selection for the sequencer.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start_i) state_nxt = RUN;
      RUN:     if (cnt == CNT_LAST) state_nxt = DONE;
      DONE:    state_nxt = start_i ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operand shifters, partial result, carry and bit counter.
  // Subtraction is A + ~B + 1: B is inverted on load and the carry seeded with 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa     <= '0;
      sb     <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      sa    <= a_i;
      sb    <= sub_i ? ~b_i : b_i;
      carry <= sub_i;
      cnt   <= '0;
    end else if (state == RUN) begin
      sa     <= {1'b0, sa[WIDTH-1:1]};
      sb     <= {1'b0, sb[WIDTH-1:1]};
      res_sh <= res_next;
      carry  <= fa_cout;
      if (!last_bit) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Output registers change only when the final bit completes, so partial
  // shifts are never visible. C is the raw carry out, which for subtraction
  // is the no-borrow indication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      flags_q  <= '0;
    end else if (last_bit) begin
      result_q <= res_next;
      flags_q  <= pack_flags(fa_sum, zero_next, fa_cout, c_msb ^ fa_cout);
    end
  end

  assign busy_o   = (state == RUN);
  assign done_o   = (state == DONE);
  assign result_o = result_q;
  assign flags_o  = flags_q;

endmodule

// File: tb/tb_serial_adder_unit.sv
// Self-checking bench for serial_adder_unit (WIDTH=64).
`timescale 1ps/1ps
module tb_serial_adder_unit;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_i;
  logic         sub_i;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] result_o;
  logic [3:0]   flags_o;

  int checks = 0;
  int errors = 0;

  serial_adder_unit #(
    .WIDTH      (W),
    .GATE_DELAY (50)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .sub_i    (sub_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o),
    .flags_o  (flags_o)
  );

  always #500 clk = ~clk;

  // Reference: two's-complement arithmetic on integers, ARM NZCV rules.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic sub, output logic [W-1:0] r,
                                output logic [3:0] f);
    logic [W:0] wide;
    logic       c;
    logic       v;
    if (!sub) begin
      wide = {1'b0, a} + {1'b0, b};
      r    = wide[W-1:0];
      c    = wide[W];
      v    = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
    end else begin
      r = a - b;
      c = (a >= b);
      v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
    end
    f = {r[W-1], (r == '0), c, v};
  endfunction

  function automatic logic [W-1:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // Issue one operation from an idle/done state and wait for its done pulse.
  // lat counts cycles after the accepting edge (-1 on timeout).
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        output logic [W-1:0] r, output logic [3:0] f,
                        output int lat, output int busy_n);
    @(negedge clk);
    start_i = 1'b1; a_i = a; b_i = b; sub_i = sub;
    @(negedge clk);
    start_i = 1'b0; a_i = rand64(); b_i = rand64(); sub_i = ~sub;
    lat = -1; busy_n = 0;
    for (int i = 1; i <= 200 && lat < 0; i++) begin
      if (i > 1) @(negedge clk);
      if (busy_o) busy_n++;
      if (done_o) lat = i;
    end
    r = result_o;
    f = flags_o;
  endtask

  task automatic test_reset();
    logic [W-1:0] r;
    logic [3:0]   f;
    int           lat, bn;
    bit           saw_done;
    rst_n = 1'b0; start_i = 1'b0; sub_i = 1'b0; a_i = '0; b_i = '0;
    #1700;
    checks++;
    if ({busy_o, done_o} !== 2'b00) begin
      errors++; $display("FAIL reset_ctrl busy/done=%b expected 00", {busy_o, done_o});
    end
    checks++;
    if ({result_o, flags_o} !== '0) begin
      errors++; $display("FAIL reset_data result=%h flags=%b expected 0", result_o, flags_o);
    end
    @(negedge clk); rst_n = 1'b1;

    run_op(64'd9, 64'd10, 1'b0, r, f, lat, bn);
    checks++;
    if (r !== 64'd19) begin
      errors++; $display("FAIL pre_abort_result got %h expected %h", r, 64'd19);
    end

    // Start an operation and pull reset in the middle of the bit-30 cycle.
    @(negedge clk);
    start_i = 1'b1; a_i = 64'h1234_5678_9ABC_DEF0; b_i = 64'h0FED_CBA9_8765_4321; sub_i = 1'b0;
    @(negedge clk);
    start_i = 1'b0;
    repeat (29) @(negedge clk);
    #200 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy_o, done_o, result_o, flags_o} !== '0) begin
      errors++;
      $display("FAIL abort_outputs busy=%b done=%b result=%h flags=%b expected all 0",
               busy_o, done_o, result_o, flags_o);
    end
    saw_done = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (done_o) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    repeat (70) begin
      @(negedge clk);
      if (done_o) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      errors++; $display("FAIL abort_no_done got done=%b expected 0", saw_done);
    end

    run_op(64'd3, 64'd4, 1'b0, r, f, lat, bn);
    checks++;
    if (r !== 64'd7 || lat !== 65) begin
      errors++; $display("FAIL post_reset_add result=%h lat=%0d expected 7 lat 65", r, lat);
    end
  endtask

  task automatic test_simple_add();
    logic [W-1:0] r;
    logic [3:0]   f;
    int           lat, bn;
    run_op(64'd5, 64'd7, 1'b0, r, f, lat, bn);
    checks++;
    if (lat !== 65) begin
      errors++; $display("FAIL add_latency got %0d expected 65", lat);
    end
    checks++;
    if (bn !== 64) begin
      errors++; $display("FAIL add_busy_cycles got %0d expected 64", bn);
    end
    checks++;
    if (r !== 64'd12 || f !== 4'b0000) begin
      errors++; $display("FAIL add_5_7 result=%h flags=%b expected c 0000", r, f);
    end
  endtask

  task automatic test_directed_flags();
    logic [W-1:0] r;
    logic [3:0]   f;
    int           lat, bn;
    run_op(64'd5, 64'd5, 1'b1, r, f, lat, bn);
    checks++;
    if (r !== 64'd0 || f !== 4'b0110) begin
      errors++; $display("FAIL sub_zero result=%h flags=%b expected 0 0110", r, f);
    end
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, r, f, lat, bn);
    checks++;
    if (r !== 64'h8000_0000_0000_0000 || f !== 4'b1001) begin
      errors++; $display("FAIL overflow result=%h flags=%b expected 8000000000000000 1001", r, f);
    end
    run_op(64'd0, 64'd1, 1'b1, r, f, lat, bn);
    checks++;
    if (r !== 64'hFFFF_FFFF_FFFF_FFFF || f !== 4'b1000) begin
      errors++; $display("FAIL borrow result=%h flags=%b expected ffffffffffffffff 1000", r, f);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, r, er;
    logic [3:0]   f, ef;
    logic [W-1:0] corner [4];
    logic         sub;
    int           lat, bn;
    corner[0] = '0;
    corner[1] = '1;
    corner[2] = 64'h8000_0000_0000_0000;
    corner[3] = 64'h7FFF_FFFF_FFFF_FFFF;
    for (int n = 0; n < 24; n++) begin
      a   = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : rand64();
      b   = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : rand64();
      sub = $urandom_range(0, 1);
      model(a, b, sub, er, ef);
      run_op(a, b, sub, r, f, lat, bn);
      checks++;
      if (r !== er || f !== ef || lat !== 65) begin
        errors++;
        $display("FAIL random_%0d a=%h b=%h sub=%b got %h/%b lat %0d expected %h/%b lat 65",
                 n, a, b, sub, r, f, lat, er, ef);
      end
    end
  endtask

  task automatic test_start_during_run();
    logic [W-1:0] a, b, er;
    logic [3:0]   ef;
    int           lat;
    a = rand64(); b = rand64();
    model(a, b, 1'b1, er, ef);
    @(negedge clk);
    start_i = 1'b1; a_i = a; b_i = b; sub_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    lat = -1;
    for (int i = 1; i <= 200 && lat < 0; i++) begin
      if (i > 1) @(negedge clk);
      if (i == 10) begin
        start_i = 1'b1; a_i = rand64(); b_i = rand64(); sub_i = 1'b0;
      end else begin
        start_i = 1'b0;
      end
      if (done_o) lat = i;
    end
    checks++;
    if (lat !== 65) begin
      errors++; $display("FAIL run_start_latency got %0d expected 65", lat);
    end
    checks++;
    if (result_o !== er || flags_o !== ef) begin
      errors++; $display("FAIL run_start_result got %h/%b expected %h/%b", result_o, flags_o, er, ef);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b, r, er;
    logic [3:0]   f, ef;
    int           lat, bn;
    bit           busy_seen;
    a = rand64(); b = rand64();
    model(a, b, 1'b0, er, ef);
    run_op(a, b, 1'b0, r, f, lat, bn);
    checks++;
    if (r !== er || f !== ef) begin
      errors++; $display("FAIL b2b_first got %h/%b expected %h/%b", r, f, er, ef);
    end
    // Still in the done cycle: request the next operation immediately.
    start_i = 1'b1; a_i = 64'hFFFF_FFFF_FFFF_FFFF; b_i = 64'd1; sub_i = 1'b0;
    @(negedge clk);
    start_i = 1'b0;
    busy_seen = busy_o;
    lat = -1;
    for (int i = 1; i <= 200 && lat < 0; i++) begin
      if (i > 1) @(negedge clk);
      if (done_o) lat = i;
    end
    checks++;
    if (busy_seen !== 1'b1 || lat !== 65) begin
      errors++; $display("FAIL b2b_accept busy=%b lat=%0d expected busy 1 lat 65", busy_seen, lat);
    end
    checks++;
    if (result_o !== 64'd0 || flags_o !== 4'b0110) begin
      errors++; $display("FAIL b2b_wrap result=%h flags=%b expected 0 0110", result_o, flags_o);
    end
    @(negedge clk);
    checks++;
    if (done_o !== 1'b0 || result_o !== 64'd0) begin
      errors++; $display("FAIL done_pulse_hold done=%b result=%h expected 0 0", done_o, result_o);
    end
  endtask

  initial begin
    test_reset();
    test_simple_add();
    test_directed_flags();
    test_random();
    test_start_during_run();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
